// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts a gated bit stream into a WIDTH-bit window and
// pulses match (plus a saturating count) when the window equals a programmable pattern.
module serial_pattern_detector #(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [WIDTH-1:0] pattern,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [WIDTH-1:0] window,
    output logic             armed
);

    localparam int FILL_W = $clog2(WIDTH) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [FILL_W-1:0] fill;
    logic [WIDTH-1:0]  nxt;
    logic              hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The compare looks at the window as it will be after this edge's shift,
    // so the bit completing the first fill is already eligible.
    assign nxt = {window[WIDTH-2:0], din};
    assign hit = en && (nxt == pattern) && (state == S_RUN || fill == FILL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FILL;
            armed     <= 1'b0;
            fill      <= '0;
            window    <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;

            if (clr_cnt)
                match_cnt <= '0;
            else if (hit)
                match_cnt <= sat_inc(match_cnt);

            if (en) begin
                window <= nxt;
                // Without overlap a match consumes the window: refill from scratch.
                if (OVERLAP == 0 && hit) begin
                    state <= S_FILL;
                    armed <= 1'b0;
                    fill  <= '0;
                end else if (state == S_FILL) begin
                    if (fill == FILL_LAST) begin
                        state <= S_RUN;
                        armed <= 1'b1;
                        fill  <= '0;
                    end else begin
                        fill <= fill + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three instances (overlap, non-overlap, 2-bit
// counter) share one stimulus and are checked each cycle against a bit-history model.
module tb_serial_pattern_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic [3:0] pattern;
    logic       clr_cnt;

    logic       match_a, match_b, match_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [3:0] window_a, window_b, window_c;
    logic       armed_a, armed_b, armed_c;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: last four accepted bits, bits accepted since the
    // window was last emptied, and the expected counter / pulse.
    logic [3:0] m_win   [3];
    int         m_fresh [3];
    int         m_cnt   [3];
    logic       m_match [3];
    int         m_max   [3] = '{255, 255, 3};
    bit         m_ov    [3] = '{1'b1, 1'b0, 1'b1};

    serial_pattern_detector #(.WIDTH(4), .CNT_W(8), .OVERLAP(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .match(match_a), .match_cnt(cnt_a), .window(window_a), .armed(armed_a)
    );
    serial_pattern_detector #(.WIDTH(4), .CNT_W(8), .OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .match(match_b), .match_cnt(cnt_b), .window(window_b), .armed(armed_b)
    );
    serial_pattern_detector #(.WIDTH(4), .CNT_W(2), .OVERLAP(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .match(match_c), .match_cnt(cnt_c), .window(window_c), .armed(armed_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_win[i]   = 4'b0000;
            m_fresh[i] = 0;
            m_cnt[i]   = 0;
            m_match[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            m_match[i] = 1'b0;
            if (en) begin
                m_win[i] = (m_win[i] << 1) | {3'b000, din};
                if (m_fresh[i] < 1000) m_fresh[i]++;
                if (m_fresh[i] >= 4 && m_win[i] == pattern) m_match[i] = 1'b1;
                if (m_match[i] && !m_ov[i]) m_fresh[i] = 0;
            end
            if (clr_cnt) m_cnt[i] = 0;
            else if (m_match[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic check_all();
        chk("match_a",  match_a,  m_match[0]);
        chk("cnt_a",    cnt_a,    m_cnt[0]);
        chk("window_a", window_a, m_win[0]);
        chk("armed_a",  armed_a,  m_fresh[0] >= 4);
        chk("match_b",  match_b,  m_match[1]);
        chk("cnt_b",    cnt_b,    m_cnt[1]);
        chk("window_b", window_b, m_win[1]);
        chk("armed_b",  armed_b,  m_fresh[1] >= 4);
        chk("match_c",  match_c,  m_match[2]);
        chk("cnt_c",    cnt_c,    m_cnt[2]);
        chk("window_c", window_c, m_win[2]);
        chk("armed_c",  armed_c,  m_fresh[2] >= 4);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_match_a"}, match_a, 0);
        chk({tag, "_cnt_a"}, cnt_a, 0);
        chk({tag, "_win_a"}, window_a, 0);
        chk({tag, "_armed_a"}, armed_a, 0);
        chk({tag, "_match_b"}, match_b, 0);
        chk({tag, "_cnt_b"}, cnt_b, 0);
        chk({tag, "_cnt_c"}, cnt_c, 0);
        chk({tag, "_armed_c"}, armed_c, 0);
    endtask

    task automatic cyc(input logic e, input logic d, input logic c);
        @(negedge clk);
        en = e; din = d; clr_cnt = c;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        rst = 1'b1;
        #2;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        rst = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0; pattern = 4'b1011;
        model_reset();
        #2;
        check_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Stream 1,0,1,1,0,1,1 on overlapping and non-overlapping instances
        s1 = 7'b1011011;
        for (int i = 6; i >= 0; i--) cyc(1'b1, s1[i], 1'b0);
        chk("t1_cnt_ov", cnt_a, 2);
        chk("t2_cnt_nov", cnt_b, 1);

        // Fill guard on an all-zero pattern
        do_reset("rst3");
        pattern = 4'b0000;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("t3_cnt_ov", cnt_a, 3);
        chk("t3_cnt_nov", cnt_b, 1);

        // en gating: stall with din toggling
        do_reset("rst4");
        pattern = 4'b1011;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, logic'(i % 2), 1'b0);
            chk("t4_stall_win", window_a, 4'b0010);
        end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t4_cnt", cnt_a, 1);

        // Saturation of the 2-bit counter, then clear coincident with a match
        do_reset("rst5");
        pattern = 4'b1111;
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("t5_sat", cnt_c, 3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t5_clr_match", match_c, 1);
        chk("t5_clr_cnt", cnt_c, 0);

        // Asynchronous reset between edges, mid-pattern
        do_reset("rst6a");
        pattern = 4'b1011;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_zero("t6_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("t6_no_early", match_a, 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t6_cnt", cnt_a, 1);

        // Randomized traffic against the model
        do_reset("rst7");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) pattern = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
- Downstream consumer of the single-bit registered D-flip-flop output stream.
- Shifts the stream into a WIDTH-bit window under an enable and compares the window against a programmable pattern.
- On a match, emits a registered one-cycle pulse and increments a saturating match counter.
- Overlapping or non-overlapping detection is selected at elaboration.

Parameters:
- WIDTH, 4: pattern/window length in bits, legal range 2..16.
- CNT_W, 8: width of the match counter.
- OVERLAP, 1: 1 = window bits may be reused across matches; 0 = a match consumes the whole window.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; din is shifted in only when en=1.
- din  input  1  serial bit, taken from the DFF stage q.
- pattern  input  WIDTH  target sequence; MSB is the oldest bit. Sampled every cycle.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.
- window  output  WIDTH  current shift register contents; MSB is the oldest bit.
- armed  output  1  1 when the window holds WIDTH valid bits (state RUN).

Behaviour:
- Reset (asynchronous, takes effect immediately, any cycle):
  - window=0, fill=0, state=FILL, match=0, match_cnt=0, armed=0.
- Shift: on a clk edge with en=1, window <= {window[WIDTH-2:0], din}. With en=0, window, fill and state hold, and match is driven 0.
- FSM:
  - FILL: each en cycle increments fill. The cycle that shifts in the WIDTH-th bit moves to RUN, and that shifted value is eligible for a match in the same edge.
  - RUN: stays in RUN while en is applied. armed = (state==RUN).
- Match condition: evaluated on the post-shift value nxt = {window[WIDTH-2:0], din}.
  - match <= en && (nxt == pattern) && (state==RUN || fill==WIDTH-1).
  - Latency: the pulse is visible in the cycle after the edge that sampled the final pattern bit.
- Non-overlap (OVERLAP=0): on a match, fill <= 0 and state <= FILL. window keeps shifting, but a further match requires WIDTH fresh bits.
- Overlap (OVERLAP=1): state stays RUN after a match, so back-to-back matches are possible. Example: pattern 1111 on a run of ones pulses every en cycle.
- Counter:
  - On a match, match_cnt increments, saturating at all-ones with no wrap.
  - clr_cnt has priority: if clr_cnt and a match occur in the same cycle, match_cnt becomes 0, but the match pulse is still emitted.
- A pattern change takes effect at the next compare. No history is rechecked.
- fill counter width: clog2(WIDTH)+1. It never exceeds WIDTH-1 in FILL.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset low, WIDTH=4, pattern=4'b1011, OVERLAP=1; en=1 every cycle with din stream 1,0,1,1,0,1,1 -> match pulses one cycle after the 4th and 7th bits; match_cnt=2; armed rises after the 4th bit.
2. Same stream with OVERLAP=0 -> single pulse after the 4th bit; match_cnt=1; armed drops for 4 cycles after the match.
3. Fill guard: pattern=4'b0000 after reset; din=0 with en=1 -> no match on bits 1-3; pulse after bit 4; further pulses every cycle with OVERLAP=1.
4. en gating: pattern 1011; feed 1,0, then hold en=0 for 5 cycles with din toggling, then 1,1 -> window shows 4'b0010 during the stall; exactly one match after the final bit.
5. Saturation and clear with CNT_W=2: six matches with pattern 1111 on all-ones -> match_cnt sticks at 3. Assert clr_cnt coincident with a match -> match_cnt=0 and match=1 in the same cycle.
6. Assert rst mid-stream, between clock edges, after 3 bits of 1011 -> window, match_cnt, armed and match are 0 immediately without a clock edge. After release, 4 new bits are required before any match.
